// File: rtl/countdown_req_pkg.sv
// Shared types and default sizing for the countdown request master.
package countdown_req_pkg;

  typedef enum logic {IDLE, REQ} req_state_t;

  localparam int DEF_LEN_W       = 4;
  localparam int DEF_WAIT_W      = 4;
  localparam int DEF_MAX_WAIT    = 10;
  localparam int DEF_BUSY_CYCLES = 10;

endpackage

// File: rtl/countdown_req_master_if.sv
// Command and request handshake bundle between upstream, the request master and its consumer.
interface countdown_req_master_if
  import countdown_req_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
);
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] burst_len;
  logic             valid_out;
  logic             ready_in;

  modport master (
    input  start_valid, burst_len, ready_in,
    output start_ready, valid_out
  );

  modport slave (
    output start_valid, burst_len, ready_in,
    input  start_ready, valid_out
  );
endinterface

// File: rtl/countdown_req_master_stall_watchdog.sv
// Consecutive-stall counter with saturation and a sticky timeout flag.
module req_stall_watchdog
  import countdown_req_pkg::*;
#(
  parameter int WAIT_W   = DEF_WAIT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              clear,
  input  logic              err_clr,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              err_timeout
);
  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic              timeout_hit;

  // NOTE: every comb output gets a default first so no path leaves a latch.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    timeout_hit = stall && (wait_cnt_q == WAIT_LIM);
    if (clear) begin
      wait_cnt_d = '0;
    end else if (stall && (wait_cnt_q != WAIT_SAT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    // A new timeout outranks a simultaneous clear request.
    err_timeout_d = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : err_timeout_q);
  end

  // NOTE: reset is synchronous active-low; state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign wait_cnt    = wait_cnt_q;
  assign err_timeout = err_timeout_q;
endmodule

// File: rtl/countdown_req_master.sv
// Burst request initiator with valid-hold, stall watchdog and completion pulse.
// Optional consumer busy-time monitor enabled by COUNTDOWN_REQ_PROTO_CHECK_EN.
module countdown_req_master
  import countdown_req_pkg::*;
#(
  parameter int LEN_W    = DEF_LEN_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int WAIT_W   = DEF_WAIT_W
`ifdef COUNTDOWN_REQ_PROTO_CHECK_EN
  , parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  countdown_req_master_if.master bus,
  output logic                   done,
  output logic [LEN_W-1:0]       remaining,
  output logic [WAIT_W-1:0]      wait_cnt,
  output logic [7:0]             acc_cnt,
  input  logic                   err_clr,
  output logic                   err_timeout
`ifdef COUNTDOWN_REQ_PROTO_CHECK_EN
  , output logic                 err_proto
`endif
);
  req_state_t       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [7:0]       acc_q, acc_d;
  logic             handshake;

  assign handshake = valid_q && bus.ready_in;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    acc_d       = acc_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.start_valid) begin
          if (bus.burst_len != '0) begin
            state_d     = REQ;
            remaining_d = bus.burst_len;
            valid_d     = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ: begin
        // Valid is held until the consumer takes the request, timeout or not.
        valid_d = 1'b1;
        if (handshake) begin
          remaining_d = remaining_q - LEN_W'(1);
          acc_d       = acc_q + 8'd1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      acc_q       <= acc_d;
    end
  end

  req_stall_watchdog #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .stall       (valid_q && !bus.ready_in),
    .clear       (handshake || (state_q == IDLE)),
    .err_clr     (err_clr),
    .wait_cnt    (wait_cnt),
    .err_timeout (err_timeout)
  );

  assign bus.start_ready = (state_q == IDLE);
  assign bus.valid_out   = valid_q;
  assign done            = done_q;
  assign remaining       = remaining_q;
  assign acc_cnt         = acc_q;

`ifdef COUNTDOWN_REQ_PROTO_CHECK_EN
  localparam int BW = $clog2(BUSY_CYCLES + 2);

  logic [BW-1:0] busy_q, busy_d;
  logic          mon_q, mon_d;
  logic          err_proto_q, err_proto_d;
  logic          proto_hit;

  // After each accept the consumer must stay low exactly BUSY_CYCLES cycles.
  always_comb begin
    busy_d    = busy_q;
    mon_d     = mon_q;
    proto_hit = 1'b0;
    if (mon_q) begin
      if (!bus.ready_in) begin
        if (busy_q != '1) busy_d = busy_q + BW'(1);
      end else begin
        proto_hit = (busy_q != BW'(BUSY_CYCLES));
        mon_d     = 1'b0;
      end
    end
    if (handshake) begin
      mon_d  = 1'b1;
      busy_d = '0;
    end
    err_proto_d = proto_hit ? 1'b1 : (err_clr ? 1'b0 : err_proto_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      mon_q       <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      mon_q       <= mon_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign err_proto = err_proto_q;
`endif
endmodule

// File: tb/tb_countdown_req_master.sv
// Self-checking bench: reset, directed vector table, stall/timeout sequences, randomized model comparison.
module tb_countdown_req_master;
  import countdown_req_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [3:0] remaining;
  logic [3:0] wait_cnt;
  logic [7:0] acc_cnt;
  logic       err_clr;
  logic       err_timeout;
`ifdef COUNTDOWN_REQ_PROTO_CHECK_EN
  logic       err_proto;
`endif

  int n_checks = 0;
  int n_errors = 0;

  countdown_req_master_if bus ();

  countdown_req_master dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .done        (done),
    .remaining   (remaining),
    .wait_cnt    (wait_cnt),
    .acc_cnt     (acc_cnt),
    .err_clr     (err_clr),
    .err_timeout (err_timeout)
`ifdef COUNTDOWN_REQ_PROTO_CHECK_EN
    , .err_proto (err_proto)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [3:0] len, input logic rdy, input logic clr);
    bus.start_valid = sv;
    bus.burst_len   = len;
    bus.ready_in    = rdy;
    err_clr         = clr;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       sv;
    logic [3:0] len;
    logic       rdy;
    logic       exp_v;
    logic       exp_d;
    logic [3:0] exp_rem;
    logic       exp_sr;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vecs[10];

  // Behavioural reference state for the random phase.
  bit in_burst;
  int left, acc, stall, err_m, done_m;

  task automatic model_step(input bit sv, input int len, input bit rdy, input bit clr);
    bit set_err;
    set_err = 0;
    done_m  = 0;
    if (!in_burst) begin
      stall = 0;
      if (sv) begin
        if (len == 0) done_m = 1;
        else begin
          in_burst = 1;
          left     = len;
        end
      end
    end else if (rdy) begin
      acc   = (acc + 1) % 256;
      left  = left - 1;
      stall = 0;
      if (left == 0) begin
        in_burst = 0;
        done_m   = 1;
      end
    end else begin
      if (stall == DEF_MAX_WAIT) set_err = 1;
      stall = (stall + 1 > 15) ? 15 : stall + 1;
    end
    if (set_err) err_m = 1;
    else if (clr) err_m = 0;
  endtask

  initial begin
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", bus.valid_out, 0);
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_acc", acc_cnt, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_remaining", remaining, 0);
    check("rst_done", done, 0);
    check("rst_wait", wait_cnt, 0);

    // Directed table: 3-burst, zero-length coinciding with done, stalled 2-burst
    vecs[0] = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 8'd1};
    vecs[2] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 8'd2};
    vecs[3] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 8'd3};
    vecs[4] = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 8'd3};
    vecs[5] = '{1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 8'd3};
    vecs[6] = '{1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 8'd3};
    vecs[7] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 8'd4};
    vecs[8] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 8'd5};
    vecs[9] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'd5};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].sv, vecs[i].len, vecs[i].rdy, 1'b0);
      cyc();
      check($sformatf("vec%0d_valid", i), bus.valid_out, vecs[i].exp_v);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_d);
      check($sformatf("vec%0d_rem", i), remaining, vecs[i].exp_rem);
      check($sformatf("vec%0d_start_ready", i), bus.start_ready, vecs[i].exp_sr);
      check($sformatf("vec%0d_acc", i), acc_cnt, vecs[i].exp_acc);
    end

    // Short stall: 4 cycles low then accept
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("stall4_wait%0d", i), wait_cnt, i);
      check("stall4_valid", bus.valid_out, 1);
    end
    bus.ready_in = 1'b1;
    cyc();
    check("stall4_wait_clr", wait_cnt, 0);
    check("stall4_done", done, 1);
    check("stall4_err", err_timeout, 0);

    // Timeout: 11th stall sets the flag, clear in the same cycle loses
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) cyc();
    check("to_wait10", wait_cnt, 10);
    check("to_err_before", err_timeout, 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("to_err_set_wins", err_timeout, 1);
    check("to_valid_held", bus.valid_out, 1);
    cyc();
    check("to_err_sticky", err_timeout, 1);
    for (int i = 0; i < 8; i++) cyc();
    check("to_wait_sat", wait_cnt, 15);
    check("to_valid_still", bus.valid_out, 1);
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    cyc();
    check("to_err_cleared", err_timeout, 0);
    check("to_done", done, 1);
    check("to_valid_drop", bus.valid_out, 0);
    err_clr = 1'b0;

    // Reset mid-burst with remaining=3
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    cyc();
    check("midrst_rem3", remaining, 3);
    bus.start_valid = 1'b0;
    rst = 1'b0;
    cyc();
    check("midrst_valid", bus.valid_out, 0);
    check("midrst_done", done, 0);
    check("midrst_start_ready", bus.start_ready, 1);
    rst = 1'b1;
    cyc();
    check("midrst_done_after", done, 0);
    check("midrst_valid_after", bus.valid_out, 0);

    // Randomized phase against the reference model
    do_reset();
    in_burst = 0; left = 0; acc = 0; stall = 0; err_m = 0; done_m = 0;
    for (int i = 0; i < 3000; i++) begin
      int  thresh;
      bit  sv, rdy, clr;
      int  len;
      thresh = ((i / 200) % 2 == 0) ? 80 : 8;
      sv  = ($urandom_range(0, 99) < 40);
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      rdy = ($urandom_range(0, 99) < thresh);
      clr = ($urandom_range(0, 99) < 4);
      drive(sv, 4'(len), rdy, clr);
      model_step(sv, len, rdy, clr);
      cyc();
      check("rnd_valid", bus.valid_out, 32'(in_burst));
      check("rnd_start_ready", bus.start_ready, 32'(!in_burst));
      check("rnd_done", done, done_m);
      check("rnd_rem", remaining, left);
      check("rnd_wait", wait_cnt, stall);
      check("rnd_acc", acc_cnt, acc);
      check("rnd_err", err_timeout, err_m);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);

`ifdef COUNTDOWN_REQ_PROTO_CHECK_EN
    // Compliant consumer: 10 low cycles after each accept
    do_reset();
    drive(1'b1, 4'd2, 1'b1, 1'b0);
    cyc();
    bus.start_valid = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      bus.ready_in = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      bus.ready_in = 1'b1;
      cyc();
    end
    check("proto_ok", err_proto, 0);
    check("proto_ok_acc", acc_cnt, 2);

    // Consumer never goes busy
    do_reset();
    drive(1'b1, 4'd2, 1'b1, 1'b0);
    cyc();
    bus.start_valid = 1'b0;
    cyc();
    check("proto_first_accept", err_proto, 0);
    cyc();
    check("proto_violation", err_proto, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
